// File: rtl/heartbeat_pwm_if.sv
// heartbeat_pwm_if
// Groups the run enable and the LED/envelope observation signals of the
// heartbeat PWM stage so they can travel as one port.
//   en    : run enable, driven by the controller (low freezes the stage)
//   led   : PWM LED drive
//   level : current envelope level
//   phase : envelope FSM state encoding
//   beat  : one-cycle pulse at the start of each heartbeat
// master is the controlling/observing side, slave is the heartbeat_pwm stage.
interface heartbeat_pwm_if #(
    parameter int PWM_BITS = 8
);
    logic                en;
    logic                led;
    logic [PWM_BITS-1:0] level;
    logic [2:0]          phase;
    logic                beat;

    modport master (output en, input led, input level, input phase, input beat);
    modport slave  (input en, output led, output level, output phase, output beat);
endinterface

// File: rtl/heartbeat_pwm.sv
// heartbeat_pwm
// Produces the "lub-dub" brightness envelope (two rising/falling beats, a
// short dark gap between them and a long dark rest after the second) and
// drives the LED through a PWM comparator whose duty is latched once per
// PWM period, so the LED never glitches mid-period.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset (wins over en)
//   hb  : heartbeat_pwm_if.slave -- en in; led, level, phase, beat out
module heartbeat_pwm #(
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 64,
    parameter int STEP_SIZE    = 4,
    parameter int PEAK1        = 255,
    parameter int PEAK2        = 160,
    parameter int GAP_STEPS    = 32,
    parameter int REST_STEPS   = 256
) (
    input  logic           clk,
    input  logic           rst,
    heartbeat_pwm_if.slave hb
);

    typedef enum logic [2:0] {
        BEAT1_UP = 3'd0,
        BEAT1_DN = 3'd1,
        GAP      = 3'd2,
        BEAT2_UP = 3'd3,
        BEAT2_DN = 3'd4,
        REST     = 3'd5
    } phase_t;

    localparam int SC_W     = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int HOLD_MAX = (GAP_STEPS > REST_STEPS) ? GAP_STEPS : REST_STEPS;
    localparam int HC_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam int LVL_MAX  = (1 << PWM_BITS) - 1;
    // A step larger than full scale behaves exactly like full scale once
    // clamped, and keeping it below 2^PWM_BITS lets it fit the signed math.
    localparam int STEP_C   = (STEP_SIZE > LVL_MAX) ? LVL_MAX : STEP_SIZE;

    localparam logic        [PWM_BITS:0]   STEP_U    = (PWM_BITS+1)'(STEP_C);
    localparam logic signed [PWM_BITS:0]   STEP_S    = $signed(STEP_U);
    localparam logic        [PWM_BITS-1:0] PEAK1_L   = PWM_BITS'(PEAK1);
    localparam logic        [PWM_BITS-1:0] PEAK2_L   = PWM_BITS'(PEAK2);
    localparam logic        [SC_W-1:0]     STEP_LAST = SC_W'(STEP_PERIODS - 1);
    localparam logic        [HC_W-1:0]     GAP_LAST  = HC_W'(GAP_STEPS - 1);
    localparam logic        [HC_W-1:0]     REST_LAST = HC_W'(REST_STEPS - 1);

    // Rising step, clamped to the beat's peak; computed one bit wider so the
    // sum cannot wrap before the compare.
    function automatic logic [PWM_BITS-1:0] sat_up(input logic [PWM_BITS-1:0] lvl,
                                                   input logic [PWM_BITS-1:0] peak);
        logic [PWM_BITS:0] sum;
        sum = {1'b0, lvl} + STEP_U;
        return (sum > {1'b0, peak}) ? peak : sum[PWM_BITS-1:0];
    endfunction

    // Falling step, clamped at zero via the sign of a one-bit-wider difference.
    function automatic logic [PWM_BITS-1:0] sat_dn(input logic [PWM_BITS-1:0] lvl);
        logic signed [PWM_BITS:0] diff;
        diff = $signed({1'b0, lvl}) - STEP_S;
        return diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0];
    endfunction

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SC_W-1:0]     step_cnt;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [HC_W-1:0]     hold_cnt, hold_d;
    phase_t              phase_q, phase_d;
    logic                beat_q, beat_d;
    logic                period_end;
    logic                step_evt;

    assign period_end = hb.en && (pwm_cnt == '1);
    assign step_evt   = period_end && (step_cnt == STEP_LAST);

    // ---- period / step timing stage ----
    // duty_q samples the level before this edge's envelope update, which is
    // what gives the one-period lag between level and LED.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt  <= '0;
            step_cnt <= '0;
            duty_q   <= '0;
        end else if (hb.en) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (period_end) begin
                duty_q   <= level_q;
                step_cnt <= step_evt ? '0 : step_cnt + 1'b1;
            end
        end
    end

    // ---- envelope FSM stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= BEAT1_UP;
            level_q  <= '0;
            hold_cnt <= '0;
            beat_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            level_q  <= level_d;
            hold_cnt <= hold_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        level_d = level_q;
        hold_d  = hold_cnt;
        beat_d  = 1'b0;
        case (phase_q)
            BEAT1_UP: if (step_evt) begin
                if (level_q == PEAK1_L) phase_d = BEAT1_DN;
                else                    level_d = sat_up(level_q, PEAK1_L);
            end
            BEAT1_DN: if (step_evt) begin
                if (level_q == '0) begin
                    phase_d = GAP;
                    hold_d  = '0;
                end else begin
                    level_d = sat_dn(level_q);
                end
            end
            GAP: if (step_evt) begin
                if (hold_cnt == GAP_LAST) begin
                    phase_d = BEAT2_UP;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            BEAT2_UP: if (step_evt) begin
                if (level_q == PEAK2_L) phase_d = BEAT2_DN;
                else                    level_d = sat_up(level_q, PEAK2_L);
            end
            BEAT2_DN: if (step_evt) begin
                if (level_q == '0) begin
                    phase_d = REST;
                    hold_d  = '0;
                end else begin
                    level_d = sat_dn(level_q);
                end
            end
            REST: if (step_evt) begin
                if (hold_cnt == REST_LAST) begin
                    phase_d = BEAT1_UP;
                    hold_d  = '0;
                    beat_d  = 1'b1;
                end else begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            // Encodings 6/7 recover to a dark start on the next edge.
            default: begin
                phase_d = BEAT1_UP;
                level_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // ---- PWM compare / output stage ----
    assign hb.led   = hb.en && (pwm_cnt < duty_q);
    assign hb.level = level_q;
    assign hb.phase = phase_q;
    assign hb.beat  = beat_q;

endmodule

// File: tb/tb_heartbeat_pwm.sv
module tb_heartbeat_pwm;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    heartbeat_pwm_if #(.PWM_BITS(4)) if0 ();
    heartbeat_pwm_if #(.PWM_BITS(4)) if1 ();
    heartbeat_pwm_if #(.PWM_BITS(4)) if2 ();

    assign if0.en = en;
    assign if1.en = en;
    assign if2.en = en;

    // u0: reference plan settings; u1: step 5 clamped at peak 12; u2: peak 15
    heartbeat_pwm #(.PWM_BITS(4), .STEP_PERIODS(1), .STEP_SIZE(4), .PEAK1(12),
                    .PEAK2(8), .GAP_STEPS(2), .REST_STEPS(3))
        u0 (.clk(clk), .rst(rst), .hb(if0));
    heartbeat_pwm #(.PWM_BITS(4), .STEP_PERIODS(1), .STEP_SIZE(5), .PEAK1(12),
                    .PEAK2(8), .GAP_STEPS(2), .REST_STEPS(3))
        u1 (.clk(clk), .rst(rst), .hb(if1));
    heartbeat_pwm #(.PWM_BITS(4), .STEP_PERIODS(1), .STEP_SIZE(5), .PEAK1(15),
                    .PEAK2(8), .GAP_STEPS(2), .REST_STEPS(3))
        u2 (.clk(clk), .rst(rst), .hb(if2));

    logic [3:0] lvl_o  [NI];
    logic [2:0] ph_o   [NI];
    logic       led_o  [NI];
    logic       beat_o [NI];

    assign lvl_o[0] = if0.level;  assign ph_o[0] = if0.phase;
    assign lvl_o[1] = if1.level;  assign ph_o[1] = if1.phase;
    assign lvl_o[2] = if2.level;  assign ph_o[2] = if2.phase;
    assign led_o[0] = if0.led;    assign beat_o[0] = if0.beat;
    assign led_o[1] = if1.led;    assign beat_o[1] = if1.beat;
    assign led_o[2] = if2.led;    assign beat_o[2] = if2.beat;

    // Expected (phase, level) after each step event, one full heartbeat + 1.
    int ph_t [20] = '{0,0,0,1,1,1,1,2,2,3,3,3,4,4,4,5,5,5,0,0};
    int lv_t [NI][20] = '{
        '{4,8,12,12,8,4,0,0,0,0,4,8,8,4,0,0,0,0,0,4},
        '{5,10,12,12,7,2,0,0,0,0,5,8,8,3,0,0,0,0,0,5},
        '{5,10,15,15,10,5,0,0,0,0,5,8,8,3,0,0,0,0,0,5}
    };

    typedef struct {
        int ph;
        int lv;
        int bt;
    } exp_t;

    exp_t sb [NI][$];

    int pwm_m;
    int duty_m [NI];
    int lvl_m  [NI];
    int ph_m   [NI];
    int ledcnt [NI];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        pwm_m = 0;
        for (int i = 0; i < NI; i++) begin
            duty_m[i] = 0;
            lvl_m[i]  = 0;
            ph_m[i]   = 0;
            ledcnt[i] = 0;
            sb[i].delete();
        end
    endtask

    task automatic push_steps(input int n);
        for (int i = 0; i < NI; i++)
            for (int s = 0; s < n; s++)
                sb[i].push_back('{ph_t[s], lv_t[i][s], (s == 18) ? 1 : 0});
    endtask

    task automatic check_outs(input int i, input int bexp);
        chk($sformatf("u%0d level", i), int'(lvl_o[i]), lvl_m[i]);
        chk($sformatf("u%0d phase", i), int'(ph_o[i]), ph_m[i]);
        chk($sformatf("u%0d beat", i), int'(beat_o[i]), bexp);
        chk($sformatf("u%0d phase_legal", i), (int'(ph_o[i]) < 6) ? 1 : 0, 1);
    endtask

    // One enabled cycle: check LED against the latched duty, then advance.
    task automatic tick_en();
        int   bexp [NI];
        exp_t e;
        en = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d led pwm=%0d", i, pwm_m), int'(led_o[i]),
                (pwm_m < duty_m[i]) ? 1 : 0);
            if (led_o[i]) ledcnt[i]++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) bexp[i] = 0;
        if (pwm_m == 15) begin
            pwm_m = 0;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("u%0d led_per_period", i), ledcnt[i], duty_m[i]);
                ledcnt[i] = 0;
                duty_m[i] = lvl_m[i];
                if (sb[i].size() == 0) begin
                    chk($sformatf("u%0d sb_underflow", i), 0, 1);
                end else begin
                    e = sb[i].pop_front();
                    lvl_m[i] = e.lv;
                    ph_m[i]  = e.ph;
                    bexp[i]  = e.bt;
                end
            end
        end else begin
            pwm_m++;
        end
        for (int i = 0; i < NI; i++) check_outs(i, bexp[i]);
    endtask

    // One paused cycle: LED dark, everything frozen.
    task automatic tick_dis();
        en = 1'b0;
        #1;
        for (int i = 0; i < NI; i++)
            chk($sformatf("u%0d led_paused", i), int'(led_o[i]), 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check_outs(i, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < NI; i++) begin
            check_outs(i, 0);
            chk($sformatf("u%0d led_reset", i), int'(led_o[i]), 0);
        end
    endtask

    initial begin
        en  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        do_reset();

        // Full heartbeat plus one step: envelope, beat pulse, PWM duty.
        push_steps(20);
        repeat (320) tick_en();
        for (int i = 0; i < NI; i++)
            chk($sformatf("u%0d sb_left_run", i), sb[i].size(), 0);

        // Pause mid-period in BEAT1_DN at level 8, then resume into GAP.
        do_reset();
        push_steps(9);
        repeat (87) tick_en();
        chk("u0 level_before_pause", int'(lvl_o[0]), 8);
        repeat (50) tick_dis();
        repeat (57) tick_en();
        for (int i = 0; i < NI; i++)
            chk($sformatf("u%0d sb_left_pause", i), sb[i].size(), 0);
        chk("u0 in_gap", int'(ph_o[0]), 2);

        // Reset with en still high in GAP, then restart from step 0.
        en = 1'b1;
        do_reset();
        push_steps(3);
        repeat (48) tick_en();
        for (int i = 0; i < NI; i++)
            chk($sformatf("u%0d sb_left_rst", i), sb[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
